// File: rtl/nanosoc_ft1248_pkg.sv
// Shared constants for the FT1248 x1 device: bit-counter states and
// command decode masks.
package nanosoc_ft1248_pkg;

    localparam logic [4:0] ST_CMD_LAST = 5'd6;
    localparam logic [4:0] ST_TURN     = 5'd7;
    localparam logic [4:0] ST_DATA0    = 5'd8;
    localparam logic [4:0] ST_DATA7    = 5'd15;
    localparam logic [4:0] ST_END      = 5'd16;
    localparam logic [4:0] ST_IDLE     = 5'd31;

    // Only c6, c3, c1 and c0 take part in the decode
    localparam logic [6:0] CMD_MASK        = 7'b1001011;
    localparam logic [6:0] CMD_READ_MATCH  = 7'b0000001;
    localparam logic [6:0] CMD_WRITE_MATCH = 7'b0000000;

    typedef enum logic [1:0] {
        CMD_UNKNOWN,
        CMD_READ,
        CMD_WRITE
    } cmd_e;

    function automatic cmd_e decode_cmd(input logic [6:0] c);
        cmd_e r;
        r = CMD_UNKNOWN;
        if ((c & CMD_MASK) == CMD_READ_MATCH)
            r = CMD_READ;
        else if ((c & CMD_MASK) == CMD_WRITE_MATCH)
            r = CMD_WRITE;
        return r;
    endfunction

endpackage

// File: rtl/nanosoc_ft1248_sync_edge.sv
// Multi-flop input synchroniser with one-cycle rise/fall pulses.
// RST_VAL lets SS_N start out deasserted.
module nanosoc_ft1248_sync_edge #(
    parameter int   SYNC_STAGES = 2,
    parameter logic RST_VAL     = 1'b0
) (
    input  logic aclk,
    input  logic areset,
    input  logic d,
    output logic sync,
    output logic sync_del,
    output logic rise,
    output logic fall
);

    logic [SYNC_STAGES-1:0] chain;

    always_ff @(posedge aclk or posedge areset) begin
        if (areset) begin
            chain    <= {SYNC_STAGES{RST_VAL}};
            sync_del <= RST_VAL;
        end else begin
            chain    <= {chain[SYNC_STAGES-2:0], d};
            sync_del <= chain[SYNC_STAGES-1];
        end
    end

    assign sync = chain[SYNC_STAGES-1];
    assign rise = sync & ~sync_del;
    assign fall = ~sync & sync_del;

endmodule

// File: rtl/nanosoc_ft1248x1_device.sv
// FT1248 1-bit slave responder bridging one byte per SS_N assertion
// to a pair of 8-bit AXI-Stream ports.
module nanosoc_ft1248x1_device
    import nanosoc_ft1248_pkg::*;
#(
    parameter int   SYNC_STAGES = 2,
    parameter logic IDLE_MISO   = 1'b1
) (
    input  logic       aclk,
    input  logic       areset,
    input  logic       ft_clk_i,
    input  logic       ft_ssn_i,
    input  logic       ft_miosio_i,
    output logic       ft_miosio_o,
    output logic       ft_miosio_e_o,
    output logic       ft_miso_o,
    input  logic [7:0] txd8_tdata,
    input  logic       txd8_tvalid,
    output logic       txd8_tready,
    output logic [7:0] rxd8_tdata,
    output logic       rxd8_tvalid,
    input  logic       rxd8_tready
);

    logic       clk_s, clk_sd, clk_rise, clk_fall;
    logic       ssn, ssn_sd, ssn_rise, ssn_fall;
    logic       io_s, io_d, io_rise, io_fall;
    logic       unused_sync;

    logic [4:0] cnt;
    logic [6:0] cmd;
    logic       cmd_vld;
    logic       rd_go, wr_go, wr_done;
    logic       tx_full;
    logic [7:0] tx_buf, rx_sh;
    logic       ack_rd, ack_wr;

    nanosoc_ft1248_sync_edge #(.SYNC_STAGES(SYNC_STAGES), .RST_VAL(1'b0)) u_clk (
        .aclk(aclk), .areset(areset), .d(ft_clk_i),
        .sync(clk_s), .sync_del(clk_sd), .rise(clk_rise), .fall(clk_fall)
    );

    nanosoc_ft1248_sync_edge #(.SYNC_STAGES(SYNC_STAGES), .RST_VAL(1'b1)) u_ssn (
        .aclk(aclk), .areset(areset), .d(ft_ssn_i),
        .sync(ssn), .sync_del(ssn_sd), .rise(ssn_rise), .fall(ssn_fall)
    );

    nanosoc_ft1248_sync_edge #(.SYNC_STAGES(SYNC_STAGES), .RST_VAL(1'b0)) u_io (
        .aclk(aclk), .areset(areset), .d(ft_miosio_i),
        .sync(io_s), .sync_del(io_d), .rise(io_rise), .fall(io_fall)
    );

    assign unused_sync = ^{clk_s, clk_sd, ssn_sd, ssn_rise, ssn_fall,
                           io_s, io_rise, io_fall};

    assign txd8_tready = ~tx_full;

    always_comb begin
        ack_rd = 1'b0;
        ack_wr = 1'b0;
        unique case (decode_cmd(cmd))
            CMD_READ:  ack_rd = tx_full;
            CMD_WRITE: ack_wr = ~rxd8_tvalid;
            default:   ;
        endcase
    end

    always_ff @(posedge aclk or posedge areset) begin
        if (areset) begin
            cnt           <= ST_IDLE;
            cmd           <= '0;
            cmd_vld       <= 1'b0;
            rd_go         <= 1'b0;
            wr_go         <= 1'b0;
            wr_done       <= 1'b0;
            tx_full       <= 1'b0;
            tx_buf        <= '0;
            rx_sh         <= '0;
            rxd8_tdata    <= '0;
            rxd8_tvalid   <= 1'b0;
            ft_miso_o     <= IDLE_MISO;
            ft_miosio_o   <= 1'b0;
            ft_miosio_e_o <= 1'b0;
        end else begin
            cmd_vld <= 1'b0;
            wr_done <= 1'b0;
            if (txd8_tvalid && !tx_full) begin
                tx_buf  <= txd8_tdata;
                tx_full <= 1'b1;
            end
            if (rxd8_tvalid && rxd8_tready)
                rxd8_tvalid <= 1'b0;
            if (wr_done) begin
                rxd8_tdata  <= rx_sh;
                rxd8_tvalid <= 1'b1;
            end
            if (ssn) begin
                cnt           <= ST_IDLE;
                rd_go         <= 1'b0;
                wr_go         <= 1'b0;
                ft_miso_o     <= IDLE_MISO;
                ft_miosio_e_o <= 1'b0;
            end else begin
                // Counting up from ST_IDLE wraps to state 0 on the first rise
                if (clk_rise && cnt != ST_END)
                    cnt <= cnt + 5'd1;
                if (clk_fall && cnt <= ST_CMD_LAST) begin
                    cmd     <= {cmd[5:0], io_d};
                    cmd_vld <= (cnt == ST_CMD_LAST);
                end
                if (cmd_vld) begin
                    rd_go     <= ack_rd;
                    wr_go     <= ack_wr;
                    ft_miso_o <= ~(ack_rd | ack_wr);
                end
                if (clk_rise && rd_go) begin
                    if (cnt >= ST_TURN && cnt < ST_DATA7) begin
                        ft_miosio_e_o <= 1'b1;
                        ft_miosio_o   <= tx_buf[cnt[2:0] + 3'd1];
                    end else if (cnt == ST_DATA7) begin
                        ft_miosio_e_o <= 1'b0;
                    end
                end
                if (clk_fall && rd_go && cnt == ST_DATA7)
                    tx_full <= 1'b0;
                if (clk_fall && wr_go && cnt >= ST_DATA0 && cnt <= ST_DATA7) begin
                    rx_sh   <= {io_d, rx_sh[7:1]};
                    wr_done <= (cnt == ST_DATA7);
                end
            end
        end
    end

endmodule

// File: tb/tb_nanosoc_ft1248x1_device.sv
// Bench for the FT1248 x1 device: a behavioural master drives the serial
// link and a queue scoreboard checks the RX stream beats.
module tb_nanosoc_ft1248x1_device;

    localparam int HALF = 60;
    localparam logic [6:0] C_RD  = 7'b0000001;
    localparam logic [6:0] C_WR  = 7'b0000000;
    localparam logic [6:0] C_UNK = 7'b1000000;

    logic       aclk = 1'b0;
    logic       areset = 1'b1;
    logic       ft_clk_i = 1'b0;
    logic       ft_ssn_i = 1'b1;
    logic       ft_miosio_i = 1'b0;
    logic       ft_miosio_o, ft_miosio_e_o, ft_miso_o;
    logic [7:0] txd8_tdata;
    logic       txd8_tvalid, txd8_tready;
    logic [7:0] rxd8_tdata;
    logic       rxd8_tvalid, rxd8_tready;

    int         n_tot = 0;
    int         n_bad = 0;
    logic [7:0] rx_q[$];

    nanosoc_ft1248x1_device #(.SYNC_STAGES(2), .IDLE_MISO(1'b1)) dut (
        .aclk(aclk), .areset(areset),
        .ft_clk_i(ft_clk_i), .ft_ssn_i(ft_ssn_i),
        .ft_miosio_i(ft_miosio_i), .ft_miosio_o(ft_miosio_o),
        .ft_miosio_e_o(ft_miosio_e_o), .ft_miso_o(ft_miso_o),
        .txd8_tdata(txd8_tdata), .txd8_tvalid(txd8_tvalid),
        .txd8_tready(txd8_tready),
        .rxd8_tdata(rxd8_tdata), .rxd8_tvalid(rxd8_tvalid),
        .rxd8_tready(rxd8_tready)
    );

    always #5 aclk = ~aclk;

    task automatic chk(input string tag, input logic [31:0] got,
                       input logic [31:0] exp);
        n_tot++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    always @(negedge aclk) begin
        if (!areset && rxd8_tvalid && rxd8_tready) begin
            chk("rx_beat_expected", rx_q.size() != 0, 1);
            if (rx_q.size() != 0)
                chk("rx_data", rxd8_tdata, rx_q.pop_front());
        end
    end

    task automatic sclk_bit(input logic d);
        ft_miosio_i = d;
        ft_clk_i = 1'b1;
        #HALF;
        ft_clk_i = 1'b0;
        #HALF;
    endtask

    task automatic tx_load(input logic [7:0] b);
        int n;
        n = 0;
        @(posedge aclk); #1;
        txd8_tdata  = b;
        txd8_tvalid = 1'b1;
        while (!txd8_tready && n < 50) begin
            @(posedge aclk); #1;
            n++;
        end
        chk("tx_ready_seen", txd8_tready, 1);
        @(posedge aclk); #1;
        txd8_tvalid = 1'b0;
        chk("tx_full", txd8_tready, 0);
    endtask

    task automatic xfer(input logic [6:0] cmd, input logic [7:0] wd,
                        input int nbits, input logic ack, input logic rd,
                        input logic [7:0] rexp, input int extra);
        logic [7:0] got;
        got = '0;
        ft_ssn_i = 1'b0;
        #HALF;
        for (int i = 6; i >= 0; i--)
            sclk_bit(cmd[i]);
        ft_miosio_i = 1'b0;
        ft_clk_i = 1'b1;
        #(HALF-7);
        chk("miso_turn", ft_miso_o, !ack);
        #7;
        ft_clk_i = 1'b0;
        #HALF;
        for (int k = 0; k < nbits; k++) begin
            ft_miosio_i = wd[k];
            ft_clk_i = 1'b1;
            #(HALF-7);
            chk("oe_data", ft_miosio_e_o, rd && ack);
            got[k] = ft_miosio_o;
            #7;
            ft_clk_i = 1'b0;
            #HALF;
        end
        if (nbits == 8) begin
            ft_clk_i = 1'b1;
            #(HALF-7);
            chk("oe_end", ft_miosio_e_o, 0);
            #7;
            ft_clk_i = 1'b0;
            #HALF;
            repeat (extra) sclk_bit(1'b0);
            chk("miso_hold", ft_miso_o, !ack);
            if (rd && ack)
                chk("rd_byte", got, rexp);
        end
        ft_ssn_i = 1'b1;
        #HALF;
        chk("miso_idle", ft_miso_o, 1);
        chk("oe_idle", ft_miosio_e_o, 0);
    endtask

    initial begin
        #2ms;
        $display("FAIL timeout total=%0d bad=%0d", n_tot, n_bad);
        $fatal(1);
    end

    initial begin
        rxd8_tready = 1'b0;
        txd8_tvalid = 1'b0;
        txd8_tdata  = 8'h00;
        repeat (3) @(posedge aclk); #3;
        chk("rst_miso", ft_miso_o, 1);
        chk("rst_oe", ft_miosio_e_o, 0);
        chk("rst_io", ft_miosio_o, 0);
        chk("rst_txready", txd8_tready, 1);
        chk("rst_rxvalid", rxd8_tvalid, 0);
        chk("rst_rxdata", rxd8_tdata, 0);
        areset = 1'b0;
        repeat (4) @(posedge aclk); #3;

        rx_q.push_back(8'hA5);
        xfer(C_WR, 8'hA5, 8, 1'b1, 1'b0, 8'h00, 0);
        chk("wr_valid", rxd8_tvalid, 1);
        chk("wr_data", rxd8_tdata, 8'hA5);
        repeat (5) @(posedge aclk); #3;
        chk("wr_hold", rxd8_tvalid, 1);
        rxd8_tready = 1'b1;
        repeat (3) @(posedge aclk); #3;
        chk("wr_drained", rxd8_tvalid, 0);

        tx_load(8'h3C);
        xfer(C_RD, 8'h00, 8, 1'b1, 1'b1, 8'h3C, 0);
        chk("rd_consumed", txd8_tready, 1);

        xfer(C_RD, 8'h00, 8, 1'b0, 1'b1, 8'h00, 0);
        chk("nak_rd_tx", txd8_tready, 1);

        rxd8_tready = 1'b0;
        rx_q.push_back(8'h11);
        xfer(C_WR, 8'h11, 8, 1'b1, 1'b0, 8'h00, 0);
        xfer(C_WR, 8'h22, 8, 1'b0, 1'b0, 8'h00, 0);
        chk("nak_wr_keep", rxd8_tdata, 8'h11);
        chk("nak_wr_valid", rxd8_tvalid, 1);
        rxd8_tready = 1'b1;
        repeat (3) @(posedge aclk); #3;
        chk("nak_wr_drained", rxd8_tvalid, 0);

        xfer(C_UNK, 8'h55, 8, 1'b0, 1'b0, 8'h00, 0);
        chk("unk_rxvalid", rxd8_tvalid, 0);

        tx_load(8'h3C);
        xfer(C_RD, 8'h00, 4, 1'b1, 1'b1, 8'h00, 0);
        chk("abort_rd_kept", txd8_tready, 0);
        xfer(C_RD, 8'h00, 8, 1'b1, 1'b1, 8'h3C, 0);
        chk("abort_rd_after", txd8_tready, 1);

        xfer(C_WR, 8'h77, 4, 1'b1, 1'b0, 8'h00, 0);
        repeat (3) @(posedge aclk); #3;
        chk("abort_wr_valid", rxd8_tvalid, 0);

        rx_q.push_back(8'h01);
        xfer(C_WR, 8'h01, 8, 1'b1, 1'b0, 8'h00, 3);
        rx_q.push_back(8'h02);
        xfer(C_WR, 8'h02, 8, 1'b1, 1'b0, 8'h00, 3);
        repeat (4) @(posedge aclk); #3;
        chk("b2b_q_empty", rx_q.size(), 0);

        tx_load(8'h5A);
        ft_ssn_i = 1'b0;
        #HALF;
        repeat (8) sclk_bit(1'b0);
        repeat (3) sclk_bit(1'b1);
        areset = 1'b1;
        #12;
        chk("arst_miso", ft_miso_o, 1);
        chk("arst_oe", ft_miosio_e_o, 0);
        chk("arst_io", ft_miosio_o, 0);
        chk("arst_txready", txd8_tready, 1);
        chk("arst_rxvalid", rxd8_tvalid, 0);
        chk("arst_rxdata", rxd8_tdata, 0);
        areset = 1'b0;
        ft_ssn_i = 1'b1;
        #(2*HALF);
        rx_q.push_back(8'hFF);
        xfer(C_WR, 8'hFF, 8, 1'b1, 1'b0, 8'h00, 0);

        repeat (20) @(posedge aclk); #3;
        chk("rx_q_empty", rx_q.size(), 0);
        $display("test done: total=%0d bad=%0d", n_tot, n_bad);
        $finish;
    end

endmodule
